// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier (one multiplier bit per clock), valid/ready on both sides.
// Define SAM_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_busy
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic               mc_neg, mp_neg;
  logic [WIDTH-1:0]   mc_mag, mp_mag;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last;

  always_comb begin
    // Negating the most-negative value wraps back to 2^(N-1), which is the correct unsigned magnitude.
    mc_neg  = i_signed & i_multiplicand[WIDTH-1];
    mp_neg  = i_signed & i_multiplier[WIDTH-1];
    mc_mag  = mc_neg ? -i_multiplicand : i_multiplicand;
    mp_mag  = mp_neg ? -i_multiplier : i_multiplier;
    acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef SAM_EARLY_TERM_EN
    last    = (cnt_q == CW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    last    = (cnt_q == CW'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d  = RUN;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mc_mag};
          mplier_d = mp_mag;
          cnt_d    = '0;
          neg_d    = mc_neg ^ mp_neg;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          prod_d  = neg_q ? -acc_sum : acc_sum;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_busy    = (state_q == RUN);
  assign o_product = prod_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (WIDTH=8); latency expectations follow SAM_EARLY_TERM_EN.
module tb_seq_shift_add_multiplier;
  localparam int unsigned W = 8;
`ifdef SAM_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_signed, i_ready;
  logic [W-1:0]  a, b;
  logic          o_ready, o_valid, o_busy;
  logic [2*W-1:0] o_product;

  int unsigned   total = 0;
  int unsigned   bad   = 0;
  logic [2*W-1:0] sb[$];
  logic          rmode  = 1'b0;
  logic          rforce = 1'b0;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_signed(i_signed), .i_multiplicand(a), .i_multiplier(b),
    .o_valid(o_valid), .i_ready(i_ready), .o_product(o_product), .o_busy(o_busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [2*W-1:0] ex, ey;
    ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return ex * ey;
  endfunction

  function automatic int unsigned exp_lat(input logic [W-1:0] y, input logic s);
    logic [W-1:0] m;
    int unsigned  r;
    m = (s && y[W-1]) ? -y : y;
    r = 1;
    for (int unsigned i = 0; i < W; i++) if (m[i]) r = i + 1;
    return EARLY ? r : W;
  endfunction

  // Single driver for i_ready: random stalls in rmode, otherwise the directed value rforce.
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_ready = rmode ? ($urandom_range(0, 3) != 0) : rforce;
    end
  end

  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (sb.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else chk("prod", {16'h0, o_product}, {16'h0, sb.pop_front()});
    end
  end

  // Returns #1 after the accept edge; operands are scrambled afterwards to prove they were latched.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      input logic [2*W-1:0] exp, output logic ok);
    int unsigned n;
    n  = 0;
    ok = 1'b0;
    a = x; b = y; i_signed = s; i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      i_valid = 1'b0;
      return;
    end
    sb.push_back(exp);
    @(posedge clk); #1;
    i_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); i_signed = 1'($urandom);
    ok = 1'b1;
  endtask

  // Counts edges after the accept edge until o_valid is visible (R edges -> valid in cycle k+R+1).
  task automatic lat_check(input string tag, input int unsigned exp);
    int unsigned n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_valid && n < 40);
    chk(tag, n, exp);
  endtask

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic s, input logic [2*W-1:0] exp);
    logic ok;
    send(x, y, s, exp, ok);
    if (ok) lat_check(tag, exp_lat(y, s));
  endtask

  initial begin
    logic ok;
    int unsigned n;
    logic [W-1:0] rx, ry;
    logic rs;

    rst = 1'b1; i_valid = 1'b0; i_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_prod",  32'(o_product), 32'd0);

    rforce = 1'b1;
    send(8'd200, 8'd15, 1'b0, 16'h0BB8, ok);
    chk("busy_run", 32'(o_busy), 32'd1);
    chk("ready_run", 32'(o_ready), 32'd0);
    if (ok) lat_check("lat_200x15", exp_lat(8'd15, 1'b0));

    op("lat_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
    op("lat_m7x9",      8'hF9, 8'd9,  1'b1, 16'hFFC1);
    op("lat_0xm5",      8'd0,  8'hFB, 1'b1, 16'h0000);
    op("lat_100x1",     8'd100, 8'd1, 1'b0, 16'd100);
    op("lat_100x0",     8'd100, 8'd0, 1'b0, 16'd0);
    op("lat_100x80",    8'd100, 8'h80, 1'b0, 16'd12800);
    op("lat_u255x255",  8'd255, 8'd255, 1'b0, 16'hFE01);

    // Back-pressure: product held while a competing i_valid is presented.
    rforce = 1'b0;
    send(8'd13, 8'd11, 1'b0, 16'd143, ok);
    n = 0;
    while (!o_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    a = 8'd1; b = 8'd1; i_signed = 1'b0; i_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      chk("bp_prod",  32'(o_product), 32'd143);
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_ready", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    rforce = 1'b1;
    @(posedge clk); #2;
    chk("bp_hold_valid", 32'(o_valid), 32'd1);
    @(posedge clk); #2;
    chk("bp_after_ready", 32'(o_ready), 32'd1);
    chk("bp_after_valid", 32'(o_valid), 32'd0);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Reset during RUN cycle 3 of 255 x 255; the queued result is abandoned.
    send(8'd255, 8'd255, 1'b0, 16'hFE01, ok);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy", 32'(o_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(o_ready), 32'd1);
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_busy",  32'(o_busy),  32'd0);
    chk("mrst_prod",  32'(o_product), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(o_valid), 32'd0);
    op("lat_3x4", 8'd3, 8'd4, 1'b0, 16'd12);

    rmode = 1'b1;
    for (int unsigned i = 0; i < 5000; i++) begin
      rx = 8'($urandom); ry = 8'($urandom); rs = 1'($urandom);
      if ((i % 97) == 0) ry = 8'h80;
      if ((i % 89) == 0) ry = 8'h00;
      send(rx, ry, rs, ref_prod(rx, ry, rs), ok);
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
